conv3x3_window_mac: RTL and testbench

CONV3X3_WINDOW_MAC -- requirements
Module: conv3x3_window_mac

---
 rtl/conv3x3_window_mac.sv | 188 ++++++++++++++++++
 tb/tb_conv3x3_window_mac.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window_mac.sv
// 3x3 sliding-window convolution MAC.
// Pixels arrive one kernel row at a time (row_sel 0,1,2) and are assembled into a column;
// each completed column shifts into the window. Once three columns are present, every
// further column launches a two-stage multiply/add-tree pipeline producing one result.
module conv3x3_window_mac #(
   parameter int unsigned DW = 8,
   parameter int unsigned WW = 8,
   parameter int unsigned OW = 21
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          line_start,
   input  logic          pix_valid,
   input  logic [1:0]    row_sel,
   input  logic          pad,
   input  logic [DW-1:0] pix_in,
   input  logic          w_we,
   input  logic [3:0]    w_idx,
   input  logic [WW-1:0] w_data,
   output logic [OW-1:0] conv_out,
   output logic          out_valid,
   output logic          seq_err
);

   // Product width: zero-extended pixel (DW+1) times signed weight (WW).
   localparam int unsigned PW = DW + WW + 1;

   typedef enum logic [1:0] {StFill0, StFill1, StFill2, StRun} state_e;

   state_e                   state_q, state_d;
   logic [1:0]               exp_row_q, exp_row_d;
   logic [1:0][DW-1:0]       part_q, part_d;     // rows 0 and 1 of the column being built
   logic [2:0][2:0][DW-1:0]  win_q, win_d;       // [col][row]
   logic [8:0][WW-1:0]       weight_q;           // row-major, idx = 3*row + col
   logic                     seq_err_q, seq_err_d;
   logic                     commit;
   logic                     launch;
   logic                     prod_valid_q;
   logic signed [OW-1:0]     sum;
   logic [OW-1:0]            conv_q;
   logic                     out_valid_q;
   logic [DW-1:0]            eff_pix;

   assign eff_pix = pad ? '0 : pix_in;

   // Column assembly, window shift and fill-state sequencing.
   always_comb begin
      state_d   = state_q;
      exp_row_d = exp_row_q;
      part_d    = part_q;
      win_d     = win_q;
      seq_err_d = seq_err_q;
      commit    = 1'b0;
      if (line_start) begin
         // Dominant: a pixel presented alongside line_start is dropped.
         state_d   = StFill0;
         exp_row_d = 2'd0;
         part_d    = '0;
         win_d     = '0;
      end else if (pix_valid) begin
         if (row_sel == exp_row_q) begin
            case (exp_row_q)
               2'd0: begin
                  part_d[0] = eff_pix;
                  exp_row_d = 2'd1;
               end
               2'd1: begin
                  part_d[1] = eff_pix;
                  exp_row_d = 2'd2;
               end
               default: begin
                  commit       = 1'b1;
                  exp_row_d    = 2'd0;
                  part_d       = '0;
                  win_d[0]     = win_q[1];
                  win_d[1]     = win_q[2];
                  win_d[2][0]  = part_q[0];
                  win_d[2][1]  = part_q[1];
                  win_d[2][2]  = eff_pix;
               end
            endcase
         end else begin
            // Out-of-order row: drop the partial column; a row-0 pixel restarts it.
            seq_err_d = 1'b1;
            part_d    = '0;
            if (row_sel == 2'd0) begin
               part_d[0] = eff_pix;
               exp_row_d = 2'd1;
            end else begin
               exp_row_d = 2'd0;
            end
         end
         if (commit) begin
            case (state_q)
               StFill0: state_d = StFill1;
               StFill1: state_d = StFill2;
               default: state_d = StRun;
            endcase
         end
      end
   end

   assign launch = commit && ((state_q == StFill2) || (state_q == StRun));

   // Window, column and FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StFill0;
         exp_row_q <= 2'd0;
         part_q    <= '0;
         win_q     <= '0;
         seq_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_row_q <= exp_row_d;
         part_q    <= part_d;
         win_q     <= win_d;
         seq_err_q <= seq_err_d;
      end
   end

   // Weight file; indices 9..15 are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         weight_q <= '0;
      end else if (w_we && (w_idx < 4'd9)) begin
         weight_q[w_idx] <= w_data;
      end
   end

   // Stage 1: nine products of the post-commit window with the weights as they stand
   // before any same-cycle write, which snapshots the weights at launch.
   for (genvar k = 0; k < 9; k++) begin : g_prod
      localparam int unsigned R = k / 3;
      localparam int unsigned C = k % 3;
      logic signed [PW-1:0] pix_ext;
      logic signed [PW-1:0] w_ext;
      logic signed [PW-1:0] prod_d;
      logic signed [PW-1:0] prod_q;

      assign pix_ext = PW'({1'b0, win_d[C][R]});
      assign w_ext   = PW'($signed(weight_q[k]));
      assign prod_d  = pix_ext * w_ext;

      // Product register, loaded only on launch.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            prod_q <= '0;
         end else if (launch) begin
            prod_q <= prod_d;
         end
      end
   end

   // Stage-1 valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_valid_q <= 1'b0;
      end else begin
         prod_valid_q <= launch;
      end
   end

   // Stage 2 adder tree, full precision (OW covers 9 sign-extended products).
   always_comb begin
      sum = OW'(g_prod[0].prod_q) + OW'(g_prod[1].prod_q) + OW'(g_prod[2].prod_q)
          + OW'(g_prod[3].prod_q) + OW'(g_prod[4].prod_q) + OW'(g_prod[5].prod_q)
          + OW'(g_prod[6].prod_q) + OW'(g_prod[7].prod_q) + OW'(g_prod[8].prod_q);
   end

   // Result register; holds between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= prod_valid_q;
         if (prod_valid_q) begin
            conv_q <= sum;
         end
      end
   end

   assign conv_out  = conv_q;
   assign out_valid = out_valid_q;
   assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Directed, table-driven bench for conv3x3_window_mac.
module tb_conv3x3_window_mac;

   localparam int DW = 8;
   localparam int WW = 8;
   localparam int OW = 21;

   logic          clk;
   logic          rst;
   logic          line_start;
   logic          pix_valid;
   logic [1:0]    row_sel;
   logic          pad;
   logic [DW-1:0] pix_in;
   logic          w_we;
   logic [3:0]    w_idx;
   logic [WW-1:0] w_data;
   logic [OW-1:0] conv_out;
   logic          out_valid;
   logic          seq_err;

   conv3x3_window_mac #(.DW(DW), .WW(WW), .OW(OW)) dut (
      .clk        (clk),
      .rst        (rst),
      .line_start (line_start),
      .pix_valid  (pix_valid),
      .row_sel    (row_sel),
      .pad        (pad),
      .pix_in     (pix_in),
      .w_we       (w_we),
      .w_idx      (w_idx),
      .w_data     (w_data),
      .conv_out   (conv_out),
      .out_valid  (out_valid),
      .seq_err    (seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int            cyc;
      logic [OW-1:0] val;
   } res_t;

   res_t res_q[$];
   res_t mon_r;

   // Capture every result pulse with the cycle it was seen in.
   always @(negedge clk) begin
      if (out_valid) begin
         mon_r.cyc = cyc;
         mon_r.val = conv_out;
         res_q.push_back(mon_r);
      end
   end

   typedef struct packed {
      logic [8:0][7:0] w;
      logic [8:0][7:0] p;
      logic [8:0]      pd;
      int              exp;
   } vec_t;

   vec_t vecs [6];

   int n_chk  = 0;
   int n_pass = 0;
   int last_cyc;
   int c3;
   int c4;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int res_val(input int i);
      if (i < res_q.size()) return int'($signed(res_q[i].val));
      return 2147483647;
   endfunction

   function automatic int res_cyc(input int i);
      if (i < res_q.size()) return res_q[i].cyc;
      return -1;
   endfunction

   function automatic int out_int();
      return int'($signed(conv_out));
   endfunction

   task automatic step_pix(input logic [1:0] rs, input logic pd, input logic [7:0] px);
      @(negedge clk);
      line_start = 1'b0;
      pix_valid  = 1'b1;
      row_sel    = rs;
      pad        = pd;
      pix_in     = px;
      w_we       = 1'b0;
      last_cyc   = cyc;
   endtask

   // Idle cycles carry junk on the ignored inputs.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         line_start = 1'b0;
         pix_valid  = 1'b0;
         row_sel    = 2'd3;
         pad        = 1'b0;
         pix_in     = 8'hEE;
         w_we       = 1'b0;
      end
   endtask

   task automatic do_line_start();
      @(negedge clk);
      line_start = 1'b1;
      pix_valid  = 1'b0;
      w_we       = 1'b0;
   endtask

   task automatic write_w(input logic [3:0] idx, input logic [7:0] data);
      @(negedge clk);
      line_start = 1'b0;
      pix_valid  = 1'b0;
      w_we       = 1'b1;
      w_idx      = idx;
      w_data     = data;
   endtask

   task automatic load_all(input logic [7:0] data);
      for (int k = 0; k < 9; k++) write_w(4'(k), data);
   endtask

   task automatic send_col(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                           input logic d0, input logic d1, input logic d2);
      step_pix(2'd0, d0, p0);
      step_pix(2'd1, d1, p1);
      step_pix(2'd2, d2, p2);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      pix_valid = 1'b0;
      line_start = 1'b0;
      w_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      line_start = 1'b0;
      pix_valid = 1'b0;
      row_sel = 2'd0;
      pad = 1'b0;
      pix_in = '0;
      w_we = 1'b0;
      w_idx = '0;
      w_data = '0;

      // Hand-computed table: window index k = 3*row + col.
      for (int k = 0; k < 9; k++) begin
         vecs[0].w[k] = 8'd1;   vecs[0].p[k] = 8'd10;  vecs[0].pd[k] = 1'b0;
         vecs[1].w[k] = 8'd2;   vecs[1].p[k] = (k % 3 == 0) ? 8'd200 : 8'd5;
         vecs[1].pd[k] = (k % 3 == 0);
         vecs[2].w[k] = 8'h80;  vecs[2].p[k] = 8'd255;  vecs[2].pd[k] = 1'b0;
         vecs[3].w[k] = 8'd127; vecs[3].p[k] = 8'd255;  vecs[3].pd[k] = 1'b0;
         vecs[4].w[k] = 8'(k + 1); vecs[4].p[k] = 8'(k + 1); vecs[4].pd[k] = 1'b0;
         vecs[5].w[k] = (k % 2 == 0) ? 8'hFD : 8'd4; vecs[5].p[k] = 8'(10 * k);
         vecs[5].pd[k] = 1'b0;
      end
      vecs[0].exp = 90;
      vecs[1].exp = 60;
      vecs[2].exp = -293760;
      vecs[3].exp = 291465;
      vecs[4].exp = 285;
      vecs[5].exp = 40;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_conv_out", out_int(), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_seq_err", int'(seq_err), 0);
      rst = 1'b0;
      idle(1);

      // Single-window vectors.
      for (int i = 0; i < 6; i++) begin
         do_line_start();
         for (int k = 0; k < 9; k++) write_w(4'(k), vecs[i].w[k]);
         res_q.delete();
         for (int c = 0; c < 3; c++)
            send_col(vecs[i].p[c], vecs[i].p[3+c], vecs[i].p[6+c],
                     vecs[i].pd[c], vecs[i].pd[3+c], vecs[i].pd[6+c]);
         c3 = last_cyc;
         idle(5);
         check($sformatf("v%0d_count", i), res_q.size(), 1);
         check($sformatf("v%0d_value", i), res_val(0), vecs[i].exp);
         check($sformatf("v%0d_latency", i), res_cyc(0), c3 + 2);
         check($sformatf("v%0d_hold", i), out_int(), vecs[i].exp);
      end

      // Centre-only kernel, fourth column back-to-back.
      do_line_start();
      load_all(8'd0);
      write_w(4'd4, 8'hFF);
      res_q.delete();
      send_col(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      send_col(8'd0, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
      send_col(8'd0, 8'd33, 8'd0, 1'b0, 1'b0, 1'b0);
      c3 = last_cyc;
      send_col(8'd0, 8'd77, 8'd0, 1'b0, 1'b0, 1'b0);
      c4 = last_cyc;
      idle(5);
      check("ctr_count", res_q.size(), 2);
      check("ctr_first", res_val(0), -255);
      check("ctr_first_cyc", res_cyc(0), c3 + 2);
      check("ctr_second", res_val(1), -33);
      check("ctr_second_cyc", res_cyc(1), c4 + 2);

      // line_start after two commits, with a pixel presented in the same cycle.
      do_line_start();
      load_all(8'd1);
      res_q.delete();
      send_col(8'd9, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
      send_col(8'd9, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      line_start = 1'b1;
      pix_valid = 1'b1;
      row_sel = 2'd0;
      pad = 1'b0;
      pix_in = 8'd200;
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      c3 = last_cyc;
      idle(5);
      check("ls_count", res_q.size(), 1);
      check("ls_value", res_val(0), 9);
      check("ls_cyc", res_cyc(0), c3 + 2);
      check("ls_seq_err", int'(seq_err), 0);

      // Weight write in the launch cycle.
      do_line_start();
      res_q.delete();
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      step_pix(2'd0, 1'b0, 8'd1);
      step_pix(2'd1, 1'b0, 8'd1);
      step_pix(2'd2, 1'b0, 8'd1);
      w_we = 1'b1;
      w_idx = 4'd0;
      w_data = 8'd7;
      c3 = last_cyc;
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      c4 = last_cyc;
      idle(5);
      check("wsnap_count", res_q.size(), 2);
      check("wsnap_old", res_val(0), 9);
      check("wsnap_new", res_val(1), 15);
      check("wsnap_new_cyc", res_cyc(1), c4 + 2);

      // Reset between launch and result.
      do_line_start();
      res_q.delete();
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      send_col(8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      do_reset();
      idle(5);
      check("rstmid_count", res_q.size(), 0);
      check("rstmid_conv_out", out_int(), 0);
      check("rstmid_out_valid", int'(out_valid), 0);

      // Row sequence errors.
      check("seq_clear", int'(seq_err), 0);
      load_all(8'd1);
      res_q.delete();
      step_pix(2'd0, 1'b0, 8'd1);
      step_pix(2'd2, 1'b0, 8'd50);
      idle(1);
      check("seq_set", int'(seq_err), 1);
      send_col(8'd2, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0);
      step_pix(2'd0, 1'b0, 8'd100);
      step_pix(2'd1, 1'b0, 8'd100);
      step_pix(2'd0, 1'b0, 8'd2);
      step_pix(2'd1, 1'b0, 8'd2);
      idle(2);
      step_pix(2'd2, 1'b0, 8'd2);
      send_col(8'd2, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0);
      c3 = last_cyc;
      idle(5);
      check("seq_count", res_q.size(), 1);
      check("seq_value", res_val(0), 18);
      check("seq_cyc", res_cyc(0), c3 + 2);
      do_line_start();
      idle(1);
      check("seq_sticky", int'(seq_err), 1);
      do_reset();
      idle(1);
      check("seq_rst", int'(seq_err), 0);
      step_pix(2'd3, 1'b0, 8'd5);
      idle(1);
      check("seq_row3", int'(seq_err), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
